// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle for the hazard/scoreboard unit: ID/EXE/MEM/WB register fields,
// long-latency issue/done events, and the forward/stall/scoreboard status it returns.
interface hazard_scoreboard_unit_if #(
    parameter int NUM_SRC = 3,
    parameter int REG_AW  = 5,
    parameter int MAX_LL  = 4
);
    localparam int CW = $clog2(MAX_LL + 1);

    logic [NUM_SRC*REG_AW-1:0] rs_id;
    logic [NUM_SRC-1:0]        rs_used_id;
    logic [REG_AW-1:0]         rd_id;
    logic                      reg_write_id;
    logic                      ll_id;
    logic [NUM_SRC*REG_AW-1:0] rs_exe;
    logic [REG_AW-1:0]         rd_exe;
    logic                      mem_read_exe;
    logic                      reg_write_exe;
    logic [REG_AW-1:0]         rd_mem;
    logic                      reg_write_mem;
    logic [REG_AW-1:0]         rd_wb;
    logic                      reg_write_wb;
    logic                      ll_issue;
    logic [REG_AW-1:0]         ll_issue_rd;
    logic                      ll_done;
    logic [REG_AW-1:0]         ll_done_rd;
    logic [NUM_SRC-1:0]        fwd_id;
    logic [NUM_SRC*2-1:0]      fwd_exe;
    logic                      stall_id;
    logic [CW-1:0]             ll_count;
    logic                      sb_err;

    modport master (
        output rs_id, rs_used_id, rd_id, reg_write_id, ll_id,
        output rs_exe, rd_exe, mem_read_exe, reg_write_exe,
        output rd_mem, reg_write_mem, rd_wb, reg_write_wb,
        output ll_issue, ll_issue_rd, ll_done, ll_done_rd,
        input  fwd_id, fwd_exe, stall_id, ll_count, sb_err
    );

    modport slave (
        input  rs_id, rs_used_id, rd_id, reg_write_id, ll_id,
        input  rs_exe, rd_exe, mem_read_exe, reg_write_exe,
        input  rd_mem, reg_write_mem, rd_wb, reg_write_wb,
        input  ll_issue, ll_issue_rd, ll_done, ll_done_rd,
        output fwd_id, fwd_exe, stall_id, ll_count, sb_err
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Operand bypass selection, ID stall generation and a long-latency write scoreboard.
// One lane per source operand; the scoreboard state is shared across lanes.
module hazard_scoreboard_lane #(
    parameter int REG_AW    = 5,
    parameter int ZERO_HARD = 1
) (
    input  logic [REG_AW-1:0]    rs_id,
    input  logic                 rs_used,
    input  logic [REG_AW-1:0]    rs_exe,
    input  logic [2**REG_AW-1:0] pending,
    input  logic [REG_AW-1:0]    rd_exe,
    input  logic                 load_exe,
    input  logic [REG_AW-1:0]    rd_mem,
    input  logic                 reg_write_mem,
    input  logic [REG_AW-1:0]    rd_wb,
    input  logic                 reg_write_wb,
    input  logic                 ll_done,
    input  logic [REG_AW-1:0]    ll_done_rd,
    output logic                 fwd_id,
    output logic [1:0]           fwd_exe,
    output logic                 stall
);
    logic valid_id, valid_exe, done_match;

    assign valid_id   = (ZERO_HARD == 0) || (rs_id != '0);
    assign valid_exe  = (ZERO_HARD == 0) || (rs_exe != '0);
    assign done_match = ll_done && (ll_done_rd == rs_id);

    always_comb begin
        fwd_exe = 2'b00;
        if (valid_exe && reg_write_mem && rd_mem == rs_exe)
            fwd_exe = 2'b01;
        else if (valid_exe && reg_write_wb && rd_wb == rs_exe)
            fwd_exe = 2'b10;
    end

    // A long-latency result landing this cycle is bypassed, so it neither stalls nor misses.
    assign fwd_id = valid_id && ((reg_write_wb && rd_wb == rs_id) || done_match);
    assign stall  = rs_used && valid_id &&
                    ((load_exe && rd_exe == rs_id) || (pending[rs_id] && !done_match));
endmodule

module hazard_scoreboard_unit #(
    parameter int NUM_SRC   = 3,
    parameter int REG_AW    = 5,
    parameter int MAX_LL    = 4,
    parameter int ZERO_HARD = 1
) (
    input logic                     clk,
    input logic                     reset,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int NUM_REGS = 2**REG_AW;
    localparam int CW       = $clog2(MAX_LL + 1);

    logic [NUM_REGS-1:0] pending, pending_nxt;
    logic [CW-1:0]       count, count_nxt;
    logic                err, err_nxt;

    logic [NUM_SRC-1:0]  fwd_id_src, stall_src;
    logic [NUM_SRC*2-1:0] fwd_exe_src;

    function automatic logic is_valid(input logic [REG_AW-1:0] r);
        return (ZERO_HARD == 0) || (r != '0);
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        hazard_scoreboard_lane #(.REG_AW(REG_AW), .ZERO_HARD(ZERO_HARD)) u_lane (
            .rs_id         (bus.rs_id[i*REG_AW +: REG_AW]),
            .rs_used       (bus.rs_used_id[i]),
            .rs_exe        (bus.rs_exe[i*REG_AW +: REG_AW]),
            .pending       (pending),
            .rd_exe        (bus.rd_exe),
            .load_exe      (bus.mem_read_exe && bus.reg_write_exe),
            .rd_mem        (bus.rd_mem),
            .reg_write_mem (bus.reg_write_mem),
            .rd_wb         (bus.rd_wb),
            .reg_write_wb  (bus.reg_write_wb),
            .ll_done       (bus.ll_done),
            .ll_done_rd    (bus.ll_done_rd),
            .fwd_id        (fwd_id_src[i]),
            .fwd_exe       (fwd_exe_src[i*2 +: 2]),
            .stall         (stall_src[i])
        );
    end

    logic waw, full;
    assign waw  = bus.reg_write_id && pending[bus.rd_id] && is_valid(bus.rd_id) &&
                  !(bus.ll_done && bus.ll_done_rd == bus.rd_id);
    assign full = bus.ll_id && (count == CW'(MAX_LL)) && !bus.ll_done;

    assign bus.stall_id = !reset && ((|stall_src) || waw || full);
    assign bus.fwd_id   = reset ? '0 : fwd_id_src;
    assign bus.fwd_exe  = reset ? '0 : fwd_exe_src;
    assign bus.ll_count = reset ? '0 : count;
    assign bus.sb_err   = !reset && err;

    logic done_hit, issue_req, issue_ok;

    always_comb begin
        done_hit    = bus.ll_done && is_valid(bus.ll_done_rd) && pending[bus.ll_done_rd];
        issue_req   = bus.ll_issue && is_valid(bus.ll_issue_rd);
        // A retiring op frees a slot in the same cycle, so a full board can still accept.
        issue_ok    = issue_req && ((count != CW'(MAX_LL)) || done_hit);
        pending_nxt = pending;
        if (done_hit) pending_nxt[bus.ll_done_rd] = 1'b0;
        if (issue_ok) pending_nxt[bus.ll_issue_rd] = 1'b1;
        count_nxt = count;
        if (issue_ok && !done_hit && count != CW'(MAX_LL))
            count_nxt = count + CW'(1);
        else if (done_hit && !issue_ok && count != '0)
            count_nxt = count - CW'(1);
        err_nxt = err || (bus.ll_done && !done_hit) || (issue_req && !issue_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            count   <= count_nxt;
            err     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed check of bypass priority, load-use / RAW / WAW / full stalls and scoreboard
// bookkeeping, with a second instance exercising a register file whose reg 0 is real.
module tb_hazard_scoreboard_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.NUM_SRC(3), .REG_AW(5), .MAX_LL(4)) ia ();
    hazard_scoreboard_unit_if #(.NUM_SRC(3), .REG_AW(5), .MAX_LL(4)) ib ();

    hazard_scoreboard_unit #(.NUM_SRC(3), .REG_AW(5), .MAX_LL(4), .ZERO_HARD(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia.slave));
    hazard_scoreboard_unit #(.NUM_SRC(3), .REG_AW(5), .MAX_LL(4), .ZERO_HARD(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.slave));

    function automatic logic [14:0] srcs(input logic [4:0] s0, input logic [4:0] s1,
                                         input logic [4:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        ia.rs_id = '0; ia.rs_used_id = '0; ia.rd_id = '0; ia.reg_write_id = 0; ia.ll_id = 0;
        ia.rs_exe = '0; ia.rd_exe = '0; ia.mem_read_exe = 0; ia.reg_write_exe = 0;
        ia.rd_mem = '0; ia.reg_write_mem = 0; ia.rd_wb = '0; ia.reg_write_wb = 0;
        ia.ll_issue = 0; ia.ll_issue_rd = '0; ia.ll_done = 0; ia.ll_done_rd = '0;
    endtask

    task automatic idle_b();
        ib.rs_id = '0; ib.rs_used_id = '0; ib.rd_id = '0; ib.reg_write_id = 0; ib.ll_id = 0;
        ib.rs_exe = '0; ib.rd_exe = '0; ib.mem_read_exe = 0; ib.reg_write_exe = 0;
        ib.rd_mem = '0; ib.reg_write_mem = 0; ib.rd_wb = '0; ib.reg_write_wb = 0;
        ib.ll_issue = 0; ib.ll_issue_rd = '0; ib.ll_done = 0; ib.ll_done_rd = '0;
    endtask

    // Advance one edge and settle away from it; inputs are then applied mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic [4:0] rd);
        idle_a(); ia.ll_issue = 1; ia.ll_issue_rd = rd;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_a(); idle_b();
        // Reset: bypass conditions present but every output held at zero.
        ia.rd_mem = 5'd5; ia.reg_write_mem = 1; ia.rs_exe = srcs(0, 5, 0);
        ia.ll_id = 1;
        tick(); tick();
        chk("rst_fwd_exe", ia.fwd_exe, 0);
        chk("rst_count", ia.ll_count, 0);
        chk("rst_err", ia.sb_err, 0);
        chk("rst_stall", ia.stall_id, 0);
        reset = 1'b0;
        idle_a();
        tick();

        // 1: MEM beats WB; WB alone; reg 0 never forwarded.
        ia.rd_mem = 5'd5; ia.rd_wb = 5'd5; ia.reg_write_mem = 1; ia.reg_write_wb = 1;
        ia.rs_exe = srcs(0, 5, 0); ia.rs_id = srcs(1, 2, 5);
        #1;
        chk("t1_mem_prio", ia.fwd_exe, 6'b00_01_00);
        chk("t1_fwd_id_wb", ia.fwd_id, 3'b100);
        ia.reg_write_mem = 0;
        #1;
        chk("t1_wb_only", ia.fwd_exe, 6'b00_10_00);
        ia.rd_mem = 5'd0; ia.rd_wb = 5'd0; ia.reg_write_mem = 1; ia.rs_exe = srcs(0, 0, 0);
        ia.rs_id = srcs(0, 0, 0);
        #1;
        chk("t1_reg0_exe", ia.fwd_exe, 0);
        chk("t1_reg0_id", ia.fwd_id, 0);

        // 2: load-use stalls only while the load sits in EXE and the source is used.
        idle_a();
        ia.mem_read_exe = 1; ia.reg_write_exe = 1; ia.rd_exe = 5'd7;
        ia.rs_id = srcs(7, 0, 0); ia.rs_used_id = 3'b001;
        #1;
        chk("t2_load_use", ia.stall_id, 1);
        tick();
        ia.mem_read_exe = 0; ia.reg_write_exe = 0; ia.rd_exe = 5'd0;
        #1;
        chk("t2_released", ia.stall_id, 0);
        ia.mem_read_exe = 1; ia.reg_write_exe = 1; ia.rd_exe = 5'd7; ia.rs_used_id = 3'b000;
        #1;
        chk("t2_unused_src", ia.stall_id, 0);

        // 3: RAW on a pending long-latency result, bypassed on its done cycle.
        idle_a();
        ia.ll_id = 1; ia.reg_write_id = 1; ia.rd_id = 5'd9;
        ia.ll_issue = 1; ia.ll_issue_rd = 5'd9;
        #1;
        chk("t3_issue_nostall", ia.stall_id, 0);
        tick();
        chk("t3_count1", ia.ll_count, 1);
        idle_a();
        ia.rs_id = srcs(0, 9, 0); ia.rs_used_id = 3'b010;
        #1;
        chk("t3_raw_stall", ia.stall_id, 1);
        tick();
        chk("t3_raw_hold", ia.stall_id, 1);
        ia.ll_done = 1; ia.ll_done_rd = 5'd9;
        #1;
        chk("t3_done_nostall", ia.stall_id, 0);
        chk("t3_done_fwd", ia.fwd_id, 3'b010);
        tick();
        idle_a();
        #1;
        chk("t3_count0", ia.ll_count, 0);
        chk("t3_err", ia.sb_err, 0);

        // 4: fill the scoreboard, full stall, then issue+done at full.
        issue_a(5'd1); issue_a(5'd2); issue_a(5'd3); issue_a(5'd4);
        idle_a();
        chk("t4_count4", ia.ll_count, 4);
        ia.ll_id = 1;
        #1;
        chk("t4_full_stall", ia.stall_id, 1);
        ia.ll_issue = 1; ia.ll_issue_rd = 5'd5; ia.ll_done = 1; ia.ll_done_rd = 5'd1;
        #1;
        chk("t4_full_done_nostall", ia.stall_id, 0);
        tick();
        idle_a();
        chk("t4_count_stays", ia.ll_count, 4);
        chk("t4_no_err", ia.sb_err, 0);
        // pending now {2,3,4,5}; WAW on 4, lifted by a same-cycle done of 4.
        ia.reg_write_id = 1; ia.rd_id = 5'd4;
        #1;
        chk("t4_waw_stall", ia.stall_id, 1);
        ia.ll_done = 1; ia.ll_done_rd = 5'd4;
        #1;
        chk("t4_waw_done", ia.stall_id, 0);
        idle_a();

        // 5: set wins on same-reg issue+done; spurious done is a sticky error.
        ia.ll_issue = 1; ia.ll_issue_rd = 5'd3; ia.ll_done = 1; ia.ll_done_rd = 5'd3;
        tick();
        idle_a();
        ia.rs_id = srcs(3, 0, 0); ia.rs_used_id = 3'b001;
        #1;
        chk("t5_still_pending", ia.stall_id, 1);
        chk("t5_count", ia.ll_count, 4);
        chk("t5_no_err", ia.sb_err, 0);
        idle_a();
        ia.ll_done = 1; ia.ll_done_rd = 5'd12;
        tick();
        idle_a();
        chk("t5_spurious_err", ia.sb_err, 1);
        chk("t5_spurious_count", ia.ll_count, 4);
        ia.ll_issue = 1; ia.ll_issue_rd = 5'd20;
        tick();
        idle_a();
        ia.rs_id = srcs(20, 0, 0); ia.rs_used_id = 3'b001;
        #1;
        chk("t5_full_ignored", ia.stall_id, 0);
        chk("t5_full_count", ia.ll_count, 4);
        tick();
        chk("t5_err_sticky", ia.sb_err, 1);

        // 6: reset mid-operation clears the board; a stale done flags an error.
        idle_a();
        reset = 1'b1;
        ia.rs_id = srcs(2, 0, 0); ia.rs_used_id = 3'b001;
        ia.rd_wb = 5'd2; ia.reg_write_wb = 1;
        #1;
        chk("t6_rst_stall", ia.stall_id, 0);
        chk("t6_rst_fwd", ia.fwd_id, 0);
        tick();
        reset = 1'b0;
        ia.reg_write_wb = 0;
        #1;
        chk("t6_count0", ia.ll_count, 0);
        chk("t6_err0", ia.sb_err, 0);
        chk("t6_not_pending", ia.stall_id, 0);
        idle_a();
        ia.ll_done = 1; ia.ll_done_rd = 5'd2;
        tick();
        idle_a();
        chk("t6_stale_done_err", ia.sb_err, 1);
        ia.ll_issue = 1; ia.ll_issue_rd = 5'd0;
        tick();
        idle_a();
        chk("t6_reg0_ignored", ia.ll_count, 0);

        // Reg 0 as a real register: tracked and forwarded.
        idle_b();
        ib.ll_issue = 1; ib.ll_issue_rd = 5'd0;
        tick();
        idle_b();
        ib.rs_id = srcs(0, 0, 0); ib.rs_used_id = 3'b001;
        ib.rd_mem = 5'd0; ib.reg_write_mem = 1; ib.rs_exe = srcs(0, 0, 0);
        #1;
        chk("t6b_count", ib.ll_count, 1);
        chk("t6b_reg0_stall", ib.stall_id, 1);
        chk("t6b_reg0_fwd", ib.fwd_exe, 6'b01_01_01);
        chk("t6b_err", ib.sb_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
